// File: rtl/itcm_axi_rd_slave.sv
`default_nettype none
// ============================================================================
// Module   : itcm_axi_rd_slave
// Brief    : AXI4 read-only responder serving 64-bit instruction fetch bursts
//            from a synchronous single-port ITCM SRAM. A 2-entry AR queue
//            feeds a burst address generator (FIXED/INCR/WRAP). Beats pass
//            through a one-stage SRAM pipe into a credit-controlled 2-entry
//            R FIFO.
//            Optional build macro ITCM_RD_PARITY_EN adds per-byte even-parity
//            checking of SRAM read data (port mem_rpar_i).
// Revision : 1.0 - initial release
// ============================================================================
module itcm_axi_rd_slave #(
  parameter int                            C_S_AXI_ID_WIDTH   = 4,
  parameter int                            C_S_AXI_DATA_WIDTH = 64,
  parameter int                            C_S_AXI_ADDR_WIDTH = 32,
  parameter int                            MEM_DEPTH          = 4096,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = 32'h8000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          mem_req_o,
  output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mem_rdata_i
`ifdef ITCM_RD_PARITY_EN
  ,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] mem_rpar_i
`endif
);

  localparam int          c_idx_w     = $clog2(MEM_DEPTH);
  localparam int          c_idw       = C_S_AXI_ID_WIDTH;
  localparam int          c_aw        = C_S_AXI_ADDR_WIDTH;
  localparam int          c_dw        = C_S_AXI_DATA_WIDTH;
  localparam logic [63:0] c_mem_bytes = 64'(MEM_DEPTH) * 64'd8;
  localparam logic [1:0]  c_okay      = 2'b00;
  localparam logic [1:0]  c_slverr    = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // ---------------------------------------------------------------- AR queue
  logic [c_idw-1:0] r_q_id    [2];
  logic [c_aw-1:0]  r_q_addr  [2];
  logic [7:0]       r_q_len   [2];
  logic [1:0]       r_q_burst [2];
  logic             r_q_err   [2];
  logic             r_q_wptr;
  logic             r_q_rptr;
  logic [1:0]       r_q_count;

  logic w_q_full;
  logic w_q_empty;
  logic w_push;
  logic w_pop;
  logic w_len_ok;
  logic w_ar_err;

  assign w_q_full      = (r_q_count == 2'd2);
  assign w_q_empty     = (r_q_count == 2'd0);
  assign S_AXI_ARREADY = !rst && !w_q_full;
  assign w_push        = S_AXI_ARVALID && S_AXI_ARREADY;

  // Request-level errors are decided once per burst; an illegal burst type
  // (2'b11) is folded into the size error.
  assign w_len_ok = (S_AXI_ARLEN == 8'd1) || (S_AXI_ARLEN == 8'd3) ||
                    (S_AXI_ARLEN == 8'd7) || (S_AXI_ARLEN == 8'd15);
  assign w_ar_err = (S_AXI_ARSIZE != 3'b011) || (S_AXI_ARBURST == 2'b11) ||
                    ((S_AXI_ARBURST == 2'b10) && !w_len_ok);

  // Queue payload storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_id[r_q_wptr]    <= S_AXI_ARID;
      r_q_addr[r_q_wptr]  <= S_AXI_ARADDR;
      r_q_len[r_q_wptr]   <= S_AXI_ARLEN;
      r_q_burst[r_q_wptr] <= S_AXI_ARBURST;
      r_q_err[r_q_wptr]   <= w_ar_err;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_wptr  <= 1'b0;
      r_q_rptr  <= 1'b0;
      r_q_count <= 2'd0;
    end else begin
      if (w_push) r_q_wptr <= ~r_q_wptr;
      if (w_pop)  r_q_rptr <= ~r_q_rptr;
      r_q_count <= r_q_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // ------------------------------------------------------ burst generator
  logic [c_idw-1:0] r_id;
  logic [c_aw-1:0]  r_addr;
  logic [7:0]       r_len;
  logic [7:0]       r_beat;
  logic [1:0]       r_burst;
  logic             r_err;

  logic             r_p_valid;
  logic [c_idw-1:0] r_p_id;
  logic [1:0]       r_p_resp;
  logic             r_p_last;
  logic             r_p_rd;

  logic [1:0]       r_f_count;

  logic             w_credit;
  logic             w_issue;
  logic             w_last_beat;
  logic [c_aw-1:0]  w_off;
  logic             w_in_range;
  logic             w_mem_rd;
  logic             w_beat_err;
  logic [c_aw-1:0]  w_blk;
  logic [c_aw-1:0]  w_mask;
  logic [c_aw-1:0]  w_inc;
  logic [c_aw-1:0]  w_addr_nxt;

  // A beat may only be issued if it is guaranteed a FIFO slot: beats in the
  // SRAM pipe plus beats already queued must stay below the FIFO depth.
  assign w_credit    = ({2'b00, r_p_valid} + {1'b0, r_f_count}) < 3'd2;
  assign w_last_beat = (r_beat == r_len);

  assign w_off      = r_addr - BASE_ADDR;
  assign w_in_range = (64'(w_off) < c_mem_bytes);
  assign w_mem_rd   = w_issue && !r_err && w_in_range;
  assign w_beat_err = r_err || !w_in_range;
  assign mem_req_o  = w_mem_rd;
  assign mem_addr_o = w_mem_rd ? w_off[3 +: c_idx_w] : '0;

  // WRAP block is (len+1) beats of 8 bytes; only legal lengths reach here
  // with reads enabled, so the block size is always a power of two.
  assign w_blk  = c_aw'({r_len, 3'b000}) + c_aw'(8);
  assign w_mask = w_blk - c_aw'(1);
  assign w_inc  = r_addr + c_aw'(8);

  // Next beat address per burst type.
  always_comb begin
    w_addr_nxt = w_inc;
    case (r_burst)
      2'b00:   w_addr_nxt = r_addr;
      2'b10:   w_addr_nxt = (r_addr & ~w_mask) | (w_inc & w_mask);
      default: w_addr_nxt = w_inc;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: IDLE spends one cycle popping; BURST issues on credit
  // and chains straight into the next queued burst after its last beat.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_q_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (w_last_beat) begin
            if (!w_q_empty) w_pop       = 1'b1;
            else            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst registers: load on pop (address aligned down), advance on issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= 8'd0;
      r_beat  <= 8'd0;
      r_burst <= 2'b00;
      r_err   <= 1'b0;
    end else if (w_pop) begin
      r_id    <= r_q_id[r_q_rptr];
      r_addr  <= {r_q_addr[r_q_rptr][c_aw-1:3], 3'b000};
      r_len   <= r_q_len[r_q_rptr];
      r_beat  <= 8'd0;
      r_burst <= r_q_burst[r_q_rptr];
      r_err   <= r_q_err[r_q_rptr];
    end else if (w_issue) begin
      r_addr  <= w_addr_nxt;
      r_beat  <= r_beat + 8'd1;
    end
  end

  // SRAM pipe stage: beat attributes travel alongside the one-cycle read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_valid <= 1'b0;
      r_p_id    <= '0;
      r_p_resp  <= c_okay;
      r_p_last  <= 1'b0;
      r_p_rd    <= 1'b0;
    end else begin
      r_p_valid <= w_issue;
      r_p_id    <= r_id;
      r_p_resp  <= w_beat_err ? c_slverr : c_okay;
      r_p_last  <= w_last_beat;
      r_p_rd    <= w_mem_rd;
    end
  end

  logic [c_dw-1:0] w_p_data;
  logic [1:0]      w_p_resp;

  assign w_p_data = r_p_rd ? mem_rdata_i : '0;

`ifdef ITCM_RD_PARITY_EN
  logic [c_dw/8-1:0] w_par_bad;
  for (genvar b = 0; b < c_dw/8; b++) begin : g_par
    assign w_par_bad[b] = (^mem_rdata_i[8*b +: 8]) != mem_rpar_i[b];
  end
  assign w_p_resp = (r_p_rd && (|w_par_bad)) ? c_slverr : r_p_resp;
`else
  assign w_p_resp = r_p_resp;
`endif

  // ----------------------------------------------------------- R FIFO
  logic [c_idw-1:0] r_f_id   [2];
  logic [c_dw-1:0]  r_f_data [2];
  logic [1:0]       r_f_resp [2];
  logic             r_f_last [2];
  logic             r_f_wptr;
  logic             r_f_rptr;

  logic w_f_empty;
  logic w_f_push;
  logic w_f_pop;

  // With an empty FIFO the pipe beat is presented directly on R; it is only
  // stored if the master does not take it this cycle.
  assign w_f_empty    = (r_f_count == 2'd0);
  assign S_AXI_RVALID = !w_f_empty || r_p_valid;
  assign w_f_pop      = !w_f_empty && S_AXI_RREADY;
  assign w_f_push     = r_p_valid && !(w_f_empty && S_AXI_RREADY);

  // FIFO payload storage.
  always_ff @(posedge clk) begin
    if (w_f_push) begin
      r_f_id[r_f_wptr]   <= r_p_id;
      r_f_data[r_f_wptr] <= w_p_data;
      r_f_resp[r_f_wptr] <= w_p_resp;
      r_f_last[r_f_wptr] <= r_p_last;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_wptr  <= 1'b0;
      r_f_rptr  <= 1'b0;
      r_f_count <= 2'd0;
    end else begin
      if (w_f_push) r_f_wptr <= ~r_f_wptr;
      if (w_f_pop)  r_f_rptr <= ~r_f_rptr;
      r_f_count <= r_f_count + {1'b0, w_f_push} - {1'b0, w_f_pop};
    end
  end

  // R channel mux: FIFO head first, else the pipe beat, else all zero.
  always_comb begin
    S_AXI_RID   = '0;
    S_AXI_RDATA = '0;
    S_AXI_RRESP = c_okay;
    S_AXI_RLAST = 1'b0;
    if (!w_f_empty) begin
      S_AXI_RID   = r_f_id[r_f_rptr];
      S_AXI_RDATA = r_f_data[r_f_rptr];
      S_AXI_RRESP = r_f_resp[r_f_rptr];
      S_AXI_RLAST = r_f_last[r_f_rptr];
    end else if (r_p_valid) begin
      S_AXI_RID   = r_p_id;
      S_AXI_RDATA = w_p_data;
      S_AXI_RRESP = w_p_resp;
      S_AXI_RLAST = r_p_last;
    end
  end

endmodule
`default_nettype wire
